// File: rtl/bus_host_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_host_arbiter_if
// Brief    : Host-side and device-side bus bundle of the multi-host arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_host_arbiter_if #(
    parameter int NR_HOSTS   = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NR_HOSTS-1:0]                  host_req_i;
    logic [NR_HOSTS-1:0]                  host_gnt_o;
    logic [NR_HOSTS*ADDR_WIDTH-1:0]       host_addr_i;
    logic [NR_HOSTS-1:0]                  host_we_i;
    logic [NR_HOSTS*(DATA_WIDTH/8)-1:0]   host_be_i;
    logic [NR_HOSTS*DATA_WIDTH-1:0]       host_wdata_i;
    logic [NR_HOSTS-1:0]                  host_rvalid_o;
    logic [DATA_WIDTH-1:0]                host_rdata_o;
    logic [NR_HOSTS-1:0]                  host_err_o;
    logic                                 dev_req_o;
    logic                                 dev_gnt_i;
    logic [ADDR_WIDTH-1:0]                dev_addr_o;
    logic                                 dev_we_o;
    logic [DATA_WIDTH/8-1:0]              dev_be_o;
    logic [DATA_WIDTH-1:0]                dev_wdata_o;
    logic                                 dev_rvalid_i;
    logic [DATA_WIDTH-1:0]                dev_rdata_i;
    logic                                 dev_err_i;

    // Arbiter side
    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o
    );

    // Hosts and device as seen from outside the arbiter
    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/bus_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_host_arbiter
// Brief    : Round-robin / fixed-priority host arbiter with in-order response
//            routing through a small owner FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module bus_host_arbiter #(
    parameter int NR_HOSTS        = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ROUND_ROBIN     = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bus_host_arbiter_if.slave bus,
    output logic              busy_o,
    output logic              spurious_rvalid_o
);
    localparam int C_BE_W   = DATA_WIDTH / 8;
    localparam int C_HOST_W = (NR_HOSTS > 1) ? $clog2(NR_HOSTS) : 1;
    localparam int C_SUM_W  = C_HOST_W + 1;
    localparam int C_CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int C_IDX_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [C_HOST_W-1:0] r_ptr;
    logic                r_lock;
    logic [C_HOST_W-1:0] r_lock_host;
    logic [C_HOST_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [C_IDX_W-1:0]  r_rd_idx;
    logic [C_IDX_W-1:0]  r_wr_idx;
    logic [C_CNT_W-1:0]  r_count;
    logic                r_spurious;

    logic [C_HOST_W-1:0] w_winner;
    logic                w_found;
    logic [C_SUM_W-1:0]  w_sum;
    logic [C_HOST_W-1:0] w_cand;
    logic                w_full;
    logic                w_empty;
    logic                w_dev_req;
    logic                w_accept;
    logic                w_pop;
    logic [C_HOST_W-1:0] w_head;

    function automatic logic [C_IDX_W-1:0] f_next_idx(input logic [C_IDX_W-1:0] idx);
        return (idx == C_IDX_W'(MAX_OUTSTANDING - 1)) ? '0 : idx + 1'b1;
    endfunction

    // A stalled request keeps the bus; otherwise search from the pointer
    // (round-robin) or from index 0 (fixed priority), wrapping at NR_HOSTS.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_cand   = '0;
        if (r_lock) begin
            w_winner = r_lock_host;
            w_found  = 1'b1;
        end else begin
            for (int i = 0; i < NR_HOSTS; i++) begin
                w_sum = (ROUND_ROBIN != 0) ? ({1'b0, r_ptr} + C_SUM_W'(i)) : C_SUM_W'(i);
                if (w_sum >= C_SUM_W'(NR_HOSTS)) begin
                    w_sum = w_sum - C_SUM_W'(NR_HOSTS);
                end
                w_cand = w_sum[C_HOST_W-1:0];
                if (!w_found && bus.host_req_i[w_cand]) begin
                    w_winner = w_cand;
                    w_found  = 1'b1;
                end
            end
        end
    end

    assign w_full    = (r_count == C_CNT_W'(MAX_OUTSTANDING));
    assign w_empty   = (r_count == '0);
    assign w_dev_req = w_found & ~w_full;
    assign w_accept  = w_dev_req & bus.dev_gnt_i;
    assign w_pop     = bus.dev_rvalid_i & ~w_empty;
    assign w_head    = r_fifo[r_rd_idx];

    always_comb begin
        bus.host_gnt_o    = '0;
        bus.host_rvalid_o = '0;
        bus.host_err_o    = '0;
        bus.dev_addr_o    = '0;
        bus.dev_we_o      = 1'b0;
        bus.dev_be_o      = '0;
        bus.dev_wdata_o   = '0;
        if (w_dev_req) begin
            bus.dev_addr_o  = bus.host_addr_i[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
            bus.dev_we_o    = bus.host_we_i[w_winner];
            bus.dev_be_o    = bus.host_be_i[w_winner*C_BE_W +: C_BE_W];
            bus.dev_wdata_o = bus.host_wdata_i[w_winner*DATA_WIDTH +: DATA_WIDTH];
        end
        if (w_accept) begin
            bus.host_gnt_o[w_winner] = 1'b1;
        end
        if (w_pop) begin
            bus.host_rvalid_o[w_head] = 1'b1;
            bus.host_err_o[w_head]    = bus.dev_err_i;
        end
    end

    assign bus.dev_req_o    = w_dev_req;
    assign bus.host_rdata_o = bus.dev_rdata_i;
    assign busy_o            = (r_count != '0);
    assign spurious_rvalid_o = r_spurious;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock      <= 1'b0;
            r_lock_host <= '0;
            r_rd_idx    <= '0;
            r_wr_idx    <= '0;
            r_count     <= '0;
            r_spurious  <= 1'b0;
        end else begin
            if (w_dev_req && !bus.dev_gnt_i) begin
                r_lock      <= 1'b1;
                r_lock_host <= w_winner;
            end else if (w_accept) begin
                r_lock <= 1'b0;
            end
            if (w_accept) begin
                r_fifo[r_wr_idx] <= w_winner;
                r_wr_idx         <= f_next_idx(r_wr_idx);
            end
            if (w_pop) begin
                r_rd_idx <= f_next_idx(r_rd_idx);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.dev_rvalid_i && w_empty) begin
                r_spurious <= 1'b1;
            end
        end
    end

    generate
        if (ROUND_ROBIN != 0) begin : g_rr_ptr
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_ptr <= '0;
                end else if (w_accept) begin
                    r_ptr <= (w_winner == C_HOST_W'(NR_HOSTS - 1)) ? '0 : w_winner + 1'b1;
                end
            end
        end else begin : g_fixed_ptr
            always_ff @(posedge clk_i) begin
                r_ptr <= '0;
            end
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_bus_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_host_arbiter
// Brief    : Scoreboard bench for bus_host_arbiter, round-robin and fixed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_host_arbiter;
    localparam int NH = 3, AW = 32, DW = 32, BW = 4, MO = 2;

    typedef struct { int host; logic [31:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] data; logic err; } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [NH-1:0]    host_req   = '0;
    logic [NH*AW-1:0] host_addr  = '0;
    logic [NH-1:0]    host_we    = '0;
    logic [NH*BW-1:0] host_be    = '0;
    logic [NH*DW-1:0] host_wdata = '0;
    logic             dev_gnt    = 1'b0;
    logic             dev_rvalid = 1'b0;
    logic [DW-1:0]    dev_rdata  = '0;
    logic             dev_err    = 1'b0;
    logic             sel_fp     = 1'b0;
    logic             auto_resp  = 1'b0;

    exp_t  sb[$];
    resp_t pending[$];
    int    exp_gnt[$];

    bus_host_arbiter_if #(.NR_HOSTS(NH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rr ();
    bus_host_arbiter_if #(.NR_HOSTS(NH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fp ();
    logic busy_rr, busy_fp, spur_rr, spur_fp;

    assign bus_rr.host_req_i   = host_req;   assign bus_fp.host_req_i   = host_req;
    assign bus_rr.host_addr_i  = host_addr;  assign bus_fp.host_addr_i  = host_addr;
    assign bus_rr.host_we_i    = host_we;    assign bus_fp.host_we_i    = host_we;
    assign bus_rr.host_be_i    = host_be;    assign bus_fp.host_be_i    = host_be;
    assign bus_rr.host_wdata_i = host_wdata; assign bus_fp.host_wdata_i = host_wdata;
    assign bus_rr.dev_gnt_i    = dev_gnt;    assign bus_fp.dev_gnt_i    = dev_gnt;
    assign bus_rr.dev_rvalid_i = dev_rvalid; assign bus_fp.dev_rvalid_i = dev_rvalid;
    assign bus_rr.dev_rdata_i  = dev_rdata;  assign bus_fp.dev_rdata_i  = dev_rdata;
    assign bus_rr.dev_err_i    = dev_err;    assign bus_fp.dev_err_i    = dev_err;

    bus_host_arbiter #(.NR_HOSTS(NH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .MAX_OUTSTANDING(MO), .ROUND_ROBIN(1)) dut_rr (
        .clk_i(clk), .rst_i(rst), .bus(bus_rr), .busy_o(busy_rr), .spurious_rvalid_o(spur_rr));
    bus_host_arbiter #(.NR_HOSTS(NH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .MAX_OUTSTANDING(MO), .ROUND_ROBIN(0)) dut_fp (
        .clk_i(clk), .rst_i(rst), .bus(bus_fp), .busy_o(busy_fp), .spurious_rvalid_o(spur_fp));

    // View of whichever instance the current scenario exercises
    wire [NH-1:0] obs_gnt    = sel_fp ? bus_fp.host_gnt_o    : bus_rr.host_gnt_o;
    wire [NH-1:0] obs_rvalid = sel_fp ? bus_fp.host_rvalid_o : bus_rr.host_rvalid_o;
    wire [NH-1:0] obs_herr   = sel_fp ? bus_fp.host_err_o    : bus_rr.host_err_o;
    wire [DW-1:0] obs_rdata  = sel_fp ? bus_fp.host_rdata_o  : bus_rr.host_rdata_o;
    wire          obs_req    = sel_fp ? bus_fp.dev_req_o     : bus_rr.dev_req_o;
    wire [AW-1:0] obs_addr   = sel_fp ? bus_fp.dev_addr_o    : bus_rr.dev_addr_o;
    wire          obs_we     = sel_fp ? bus_fp.dev_we_o      : bus_rr.dev_we_o;
    wire [BW-1:0] obs_be     = sel_fp ? bus_fp.dev_be_o      : bus_rr.dev_be_o;
    wire [DW-1:0] obs_wdata  = sel_fp ? bus_fp.dev_wdata_o   : bus_rr.dev_wdata_o;
    wire          obs_busy   = sel_fp ? busy_fp : busy_rr;
    wire          obs_spur   = sel_fp ? spur_fp : spur_rr;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_for(input logic [31:0] addr);
        return (addr == 32'h100) ? 32'hDEAD_BEEF : (addr ^ 32'hC0DE_0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_resp();
        resp_t r;
        r = pending.pop_front();
        dev_rvalid = 1'b1;
        dev_rdata  = r.data;
        dev_err    = r.err;
    endtask

    task automatic idle_resp();
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_err    = 1'b0;
    endtask

    task automatic do_reset();
        auto_resp = 1'b0;
        rst       = 1'b1;
        host_req  = '0;
        dev_gnt   = 1'b0;
        idle_resp();
        tick();
        sb.delete();
        pending.delete();
        exp_gnt.delete();
        rst = 1'b0;
    endtask

    task automatic burst6(input int g0, input int g1, input int g2);
        do_reset();
        auto_resp = 1'b1;
        host_req  = 3'b111;
        dev_gnt   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_gnt.push_back(g0); exp_gnt.push_back(g1); exp_gnt.push_back(g2);
        end
        repeat (6) tick();
        host_req = '0;
        repeat (3) tick();
        check("burst_grants_left", exp_gnt.size(), 0);
        check("burst_resp_left", sb.size(), 0);
        check("burst_busy_end", obs_busy, 0);
    endtask

    // Device model: one-cycle response latency when auto_resp is set
    always @(posedge clk) begin
        #1;
        if (auto_resp) begin
            if (pending.size() > 0) send_resp();
            else idle_resp();
        end
    end

    // Monitor: expected grants on accept, scoreboard on responses
    always @(negedge clk) begin : monitor
        exp_t  e;
        resp_t r;
        int    h;
        if (!rst) begin
            if (obs_req && dev_gnt) begin
                if (exp_gnt.size() == 0) begin
                    check("unexpected_accept", obs_gnt, 0);
                end else begin
                    h = exp_gnt.pop_front();
                    check("gnt", obs_gnt, 64'(1) << h);
                    check("dev_addr", obs_addr, host_addr[h*AW +: AW]);
                    check("dev_we", obs_we, host_we[h]);
                    check("dev_be", obs_be, host_be[h*BW +: BW]);
                    check("dev_wdata", obs_wdata, host_wdata[h*DW +: DW]);
                    e.host = h;
                    e.data = data_for(host_addr[h*AW +: AW]);
                    e.err  = host_addr[h*AW + 3];
                    r.data = e.data;
                    r.err  = e.err;
                    sb.push_back(e);
                    pending.push_back(r);
                end
            end else begin
                check("gnt_idle", obs_gnt, 0);
            end
            if (dev_rvalid) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rvalid", obs_rvalid, 64'(1) << e.host);
                    check("rdata", obs_rdata, e.data);
                    check("herr", obs_herr, e.err ? (64'(1) << e.host) : 64'(0));
                end else begin
                    check("spurious_no_rvalid", obs_rvalid, 0);
                end
            end else begin
                check("rvalid_idle", obs_rvalid, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        host_addr  = {32'h0000_0100, 32'h0000_0208, 32'h0000_0010};
        host_we    = 3'b001;
        host_be    = {4'hF, 4'h3, 4'hC};
        host_wdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_AAAA};

        // Reset, idle
        do_reset();
        @(negedge clk);
        check("rst_gnt_rr", bus_rr.host_gnt_o, 0);
        check("rst_rvalid_rr", bus_rr.host_rvalid_o, 0);
        check("rst_req_rr", bus_rr.dev_req_o, 0);
        check("rst_addr_rr", bus_rr.dev_addr_o, 0);
        check("rst_wdata_rr", {bus_rr.dev_we_o, bus_rr.dev_be_o, bus_rr.dev_wdata_o}, 0);
        check("rst_status_rr", {busy_rr, spur_rr, bus_rr.host_err_o}, 0);
        check("rst_req_fp", bus_fp.dev_req_o, 0);
        check("rst_status_fp", {busy_fp, spur_fp, bus_fp.host_gnt_o, bus_fp.host_rvalid_o}, 0);

        // Single host 2 read
        tick();
        host_req  = 3'b100;
        dev_gnt   = 1'b1;
        auto_resp = 1'b1;
        exp_gnt.push_back(2);
        @(negedge clk);
        check("single_gnt", obs_gnt, 3'b100);
        check("single_busy_c0", obs_busy, 0);
        tick();
        host_req = '0;
        @(negedge clk);
        check("single_rvalid", obs_rvalid, 3'b100);
        check("single_rdata", obs_rdata, 32'hDEAD_BEEF);
        check("single_busy_c1", obs_busy, 1);
        tick();
        @(negedge clk);
        check("single_busy_c2", obs_busy, 0);

        // Continuous requests from all hosts
        sel_fp = 1'b0;
        burst6(0, 1, 2);
        sel_fp = 1'b1;
        burst6(0, 0, 0);
        sel_fp = 1'b0;

        // Stalled request keeps the bus
        do_reset();
        auto_resp = 1'b1;
        host_req  = 3'b010;
        dev_gnt   = 1'b0;
        exp_gnt.push_back(1);
        exp_gnt.push_back(0);
        @(negedge clk);
        check("stall_req", obs_req, 1);
        check("stall_addr_c0", obs_addr, 32'h208);
        tick();
        host_req = 3'b011;
        @(negedge clk);
        check("stall_addr_c1", obs_addr, 32'h208);
        tick();
        @(negedge clk);
        check("stall_addr_c2", obs_addr, 32'h208);
        tick();
        dev_gnt = 1'b1;
        tick();
        host_req = 3'b001;
        tick();
        host_req = '0;
        repeat (3) tick();
        check("stall_grants_left", exp_gnt.size(), 0);

        // Outstanding limit, drain, then a spurious response
        do_reset();
        host_req = 3'b111;
        dev_gnt  = 1'b1;
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        exp_gnt.push_back(2);
        repeat (2) tick();
        @(negedge clk);
        check("full_req_c2", obs_req, 0);
        check("full_busy", obs_busy, 1);
        tick();
        @(negedge clk);
        check("full_req_c3", obs_req, 0);
        tick();
        send_resp();
        @(negedge clk);
        check("full_req_pop_cycle", obs_req, 0);
        tick();
        idle_resp();
        @(negedge clk);
        check("full_req_after_pop", obs_req, 1);
        tick();
        host_req = '0;
        send_resp();
        tick();
        send_resp();
        tick();
        idle_resp();
        @(negedge clk);
        check("drain_busy", obs_busy, 0);
        check("drain_spur", obs_spur, 0);
        tick();
        dev_rvalid = 1'b1;
        dev_rdata  = 32'h5555_5555;
        tick();
        idle_resp();
        @(negedge clk);
        check("spur_set", obs_spur, 1);
        check("spur_busy", obs_busy, 0);
        tick();
        @(negedge clk);
        check("spur_held", obs_spur, 1);
        check("full_grants_left", exp_gnt.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
Multi-host request arbiter for the simulation system bus. It shares one downstream device port between the core instruction port, the core data port and the test-utility host. It selects one host per cycle by round-robin or fixed priority and holds the selection stable while the device stalls. It tracks outstanding transactions in order so each response is returned to the host that issued the request.

Parameters:
NrHosts, 3, number of requesting hosts; index 0 has the highest fixed priority.
AddrWidth, 32, address width.
DataWidth, 32, data width; byte enables are DataWidth/8 wide.
MaxOutstanding, 2, depth of the in-order response-owner FIFO (>=1).
RoundRobin, 1, 1 = round-robin arbitration, 0 = fixed priority.

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, synchronous, active-high
host_req_i  in  NrHosts  per-host request
host_gnt_o  out  NrHosts  per-host grant, one-hot or zero
host_addr_i  in  NrHosts*AddrWidth  packed host addresses, host h at slice h
host_we_i  in  NrHosts  per-host write enable
host_be_i  in  NrHosts*DataWidth/8  packed byte enables
host_wdata_i  in  NrHosts*DataWidth  packed write data
host_rvalid_o  out  NrHosts  per-host response valid, one-hot or zero
host_rdata_o  out  DataWidth  response data, broadcast to all hosts
host_err_o  out  NrHosts  per-host response error
dev_req_o  out  1  device request
dev_gnt_i  in  1  device accept
dev_addr_o  out  AddrWidth  device address
dev_we_o  out  1  device write enable
dev_be_o  out  DataWidth/8  device byte enables
dev_wdata_o  out  DataWidth  device write data
dev_rvalid_i  in  1  device response valid
dev_rdata_i  in  DataWidth  device response data
dev_err_i  in  1  device response error
busy_o  out  1  one or more transactions outstanding
spurious_rvalid_o  out  1  sticky flag: response arrived with no transaction outstanding

Behaviour:
- Reset, synchronous and active-high, sampled at the rising edge of clk_i:
  - priority pointer = 0; lock cleared; FIFO emptied; spurious_rvalid_o = 0.
  - All outputs are 0 during the cycle after reset.
  - Asserting reset mid-operation discards outstanding entries. Later dev_rvalid_i pulses are then spurious.
- Winner selection (combinational from registered state):
  - If the lock is set, winner = locked host, regardless of host_req_i.
  - Otherwise, with RoundRobin=1, winner = first h with host_req_i[h]=1, searching ptr, ptr+1, ... and wrapping modulo NrHosts.
  - Otherwise, with RoundRobin=0, winner = lowest requesting index.
- dev_req_o = (any eligible request) AND NOT fifo_full. dev_addr/we/be/wdata_o are the winner's slices; they are 0 when dev_req_o=0.
- host_gnt_o[winner] = dev_req_o AND dev_gnt_i, combinational, so grant arrives in the same cycle as a device accept. All other grant bits are 0.
- Lock: if dev_req_o=1 and dev_gnt_i=0, set lock and store the winner. Clear the lock on the accepting cycle. Hosts must hold request and attributes until granted; the arbiter never switches away from a stalled request.
- On accept (dev_req_o & dev_gnt_i):
  - Push the winner index into the FIFO.
  - With RoundRobin=1, ptr <= (winner+1) mod NrHosts. ptr is unchanged when there is no accept.
- On dev_rvalid_i with FIFO non-empty:
  - host_rvalid_o[head] = 1 and host_err_o[head] = dev_err_i, combinationally in the same cycle; all other bits are 0.
  - Pop the head.
  - host_rdata_o = dev_rdata_i always, broadcast.
- On dev_rvalid_i with FIFO empty: no host_rvalid_o; spurious_rvalid_o set and held until reset.
- Push and pop in the same cycle: occupancy unchanged; the popped entry is the old head.
- Full (count == MaxOutstanding): dev_req_o forced 0. The lock is not set by this stall because no device request was issued. A pop in the same cycle does not lift the block; the request is issued the next cycle, giving 1 idle cycle.
- Device response latency is at least 1 cycle after accept, so a pushed entry is never popped in its own push cycle.
- busy_o = (count != 0), registered-state derived.
- Counter and pointer widths: $clog2(MaxOutstanding+1) and $clog2(NrHosts). The pointer wraps at NrHosts, not at a power of 2.

Test Plan:
- Reset then idle, no host_req_i -> all outputs 0, busy_o=0.
- Single host: host 2 requests addr 0x100 read, dev_gnt_i=1, dev_rvalid_i one cycle later with rdata 0xDEADBEEF -> host_gnt_o=3'b100 in cycle 0; host_rvalid_o=3'b100 with rdata 0xDEADBEEF in cycle 1; busy_o high for 1 cycle.
- RoundRobin=1, all three hosts request continuously, dev_gnt_i=1, responses 1 cycle later -> grants in order 0,1,2,0,1,2. Each response is routed to the matching host in issue order.
- RoundRobin=0, same stimulus -> host 0 granted every cycle; hosts 1 and 2 are never granted.
- Stall: host 1 requests, dev_gnt_i=0 for 3 cycles, host 0 raises its request in cycle 1 -> dev_addr_o stays at host 1's address. Host 1 is granted when dev_gnt_i=1; host 0 is granted afterwards.
- MaxOutstanding=2 with responses withheld: two grants occur, then dev_req_o=0 while requests persist. After one dev_rvalid_i, a new grant occurs the following cycle. A dev_rvalid_i after everything has drained sets spurious_rvalid_o=1 and produces no host_rvalid_o.
